cla_adder_bist: RTL and testbench

//  Built-in self-test initiator for the CLA adder; the adder is the responder.

---
 rtl/cla_adder_bist.sv | 141 ++++++++++++++
 tb/tb_cla_adder_bist.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/cla_adder_bist.sv
// Exhaustive self-test initiator for a WIDTH-bit carry-lookahead adder: walks every {c0,a,b}
// vector, samples {c4,sum} after a settle time and records error count and first failure.
module cla_adder_bist #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_CNT_W     = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     sum_i,
  input  logic                 c4_i,
  output logic [WIDTH-1:0]     a_o,
  output logic [WIDTH-1:0]     b_o,
  output logic                 c0_o,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 fail_valid,
  output logic [2*WIDTH:0]     fail_vec,
  output logic [WIDTH:0]       fail_got
);

  localparam int VW   = 2 * WIDTH + 1;
  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic [VW-1:0]          vec_q;
  logic [SC_W-1:0]        settle_q;
  logic [WIDTH-1:0]       a_q, b_q;
  logic                   c0_q;
  logic                   busy_q, done_q, fail_valid_q;
  logic [ERR_CNT_W-1:0]   err_q;
  logic [VW-1:0]          fail_vec_q;
  logic [WIDTH:0]         fail_got_q;

  logic [WIDTH:0]         expected_d;
  logic [WIDTH:0]         got_d;
  logic                   mismatch_d;

  // Reference sum is kept one bit wider so the carry-out is compared too.
  assign expected_d = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, c0_q};
  assign got_d      = {c4_i, sum_i};
  assign mismatch_d = (got_d != expected_d);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vec_q        <= '0;
      settle_q     <= '0;
      a_q          <= '0;
      b_q          <= '0;
      c0_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= '0;
      fail_got_q   <= '0;
    end else if (abort) begin
      // Results are left intact so they can still be inspected after an abort.
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c0_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q      <= S_APPLY;
            vec_q        <= '0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            fail_got_q   <= '0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
          end
        end
        S_APPLY: begin
          {c0_q, a_q, b_q} <= vec_q;
          settle_q         <= '0;
          state_q          <= S_SETTLE;
        end
        S_SETTLE: begin
          if (settle_q == SETTLE_LAST) begin
            state_q <= S_CHECK;
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        S_CHECK: begin
          if (mismatch_d) begin
            if (!(&err_q)) begin
              err_q <= err_q + 1'b1;
            end
            if (!fail_valid_q) begin
              fail_valid_q <= 1'b1;
              fail_vec_q   <= {c0_q, a_q, b_q};
              fail_got_q   <= got_d;
            end
          end
          if (&vec_q) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            vec_q   <= vec_q + 1'b1;
            state_q <= S_APPLY;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign a_o        = a_q;
  assign b_o        = b_q;
  assign c0_o       = c0_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = done_q && (err_q == '0);
  assign err_count  = err_q;
  assign fail_valid = fail_valid_q;
  assign fail_vec   = fail_vec_q;
  assign fail_got   = fail_got_q;

endmodule

// File: tb/tb_cla_adder_bist.sv
// Bench for cla_adder_bist: behavioural adder with selectable faults, a cycle-count based
// model of the whole run, and a second instance with a narrow saturating error counter.
module tb_cla_adder_bist;

  localparam int W     = 4;
  localparam int S     = 1;
  localparam int P     = S + 2;
  localparam int NV    = 1 << (2 * W + 1);
  localparam int TOTAL = NV * P;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  int   fault = 0;

  logic [W-1:0] sum, a, b;
  logic         c4, c0, busy, done, pass, fv;
  logic [9:0]   err;
  logic [2*W:0] fvec;
  logic [W:0]   fgot;

  logic [W-1:0] sum2, a2, b2;
  logic         c42, c02, busy2, done2, pass2, fv2;
  logic [3:0]   err2;
  logic [2*W:0] fvec2;
  logic [W:0]   fgot2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Adder responder: 0 = correct, 1 = sum[0] stuck-at-0, 2 = carry-out stuck-at-0.
  function automatic logic [W:0] adder(input int f, input logic [2*W:0] v);
    logic [W:0] r;
    r = (W+1)'(v[2*W-1:W]) + (W+1)'(v[W-1:0]) + (W+1)'(v[2*W]);
    if (f == 1) r[0] = 1'b0;
    if (f == 2) r[W] = 1'b0;
    return r;
  endfunction

  assign {c4, sum}   = adder(fault, {c0, a, b});
  assign {c42, sum2} = adder(1, {c02, a2, b2});

  cla_adder_bist #(.WIDTH(W), .SETTLE_CYCLES(S), .ERR_CNT_W(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .sum_i(sum), .c4_i(c4), .a_o(a), .b_o(b), .c0_o(c0),
    .busy(busy), .done(done), .pass(pass), .err_count(err),
    .fail_valid(fv), .fail_vec(fvec), .fail_got(fgot)
  );

  cla_adder_bist #(.WIDTH(W), .SETTLE_CYCLES(S), .ERR_CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .sum_i(sum2), .c4_i(c42), .a_o(a2), .b_o(b2), .c0_o(c02),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_valid(fv2), .fail_vec(fvec2), .fail_got(fgot2)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Model: a run is just "n edges since the start edge"; everything follows from n.
  logic         m_rst, m_st, m_ab;
  logic         m_busy = 1'b0, m_done = 1'b0, m_fv = 1'b0;
  int           m_n = 0;
  int           m_err = 0;
  logic [2*W:0] m_ops = '0, m_fvec = '0;
  logic [W:0]   m_fgot = '0;

  always @(posedge clk) begin
    m_rst = rst_n;
    m_st  = start;
    m_ab  = abort;
    #1;
    if (!m_rst || !rst_n) begin
      m_busy = 0; m_done = 0; m_fv = 0; m_n = 0; m_err = 0;
      m_ops = '0; m_fvec = '0; m_fgot = '0;
    end else begin
      if (m_ab) begin
        m_busy = 0; m_done = 0; m_ops = '0;
      end else if (m_st && !m_busy) begin
        m_busy = 1; m_done = 0; m_n = 0; m_err = 0;
        m_fv = 0; m_fvec = '0; m_fgot = '0;
      end else if (m_busy) begin
        int v;
        logic [W:0] g, e;
        m_n++;
        m_ops = (2*W+1)'((m_n - 1) / P);
        if (m_n % P == 0) begin
          v = m_n / P - 1;
          g = adder(fault, (2*W+1)'(v));
          e = (W+1)'(v % 16 + (v / 16) % 16 + v / 256);
          if (g != e) begin
            if (m_err < 1023) m_err++;
            if (!m_fv) begin
              m_fv = 1; m_fvec = (2*W+1)'(v); m_fgot = g;
            end
          end
        end
        if (m_n == TOTAL) begin
          m_busy = 0; m_done = 1;
        end
      end
      checks++;
      if ({busy, done, pass, c0, a, b, err, fv, fvec, fgot} !==
          {m_busy, m_done, m_done && (m_err == 0), m_ops, 10'(m_err), m_fv, m_fvec, m_fgot}) begin
        errors++;
        $display("FAIL cycle t=%0t got busy=%b done=%b pass=%b ops=%h err=%0d fv=%b fvec=%h fgot=%h expected busy=%b done=%b ops=%h err=%0d fv=%b fvec=%h fgot=%h",
                 $time, busy, done, pass, {c0, a, b}, err, fv, fvec, fgot,
                 m_busy, m_done, m_ops, m_err, m_fv, m_fvec, m_fgot);
      end
    end
  end

  // Pulses start, optionally re-pulses it at cycles r1/r2 mid-run, returns edges to done.
  task automatic run(input int r1, input int r2, output int cnt);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    cnt = 0;
    while (!done && cnt < 4000) begin
      start = (cnt == r1) || (cnt == r2);
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    chk("run_timeout", {31'b0, done}, 32'd1);
  endtask

  int cnt;

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs", {busy, done, pass, c0, a, b, err, fv, fvec, fgot}, '0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_before_start", {busy, done}, 0);

    fault = 0;
    run($urandom_range(5, 700), $urandom_range(701, 1400), cnt);
    chk("clean_latency", cnt, TOTAL);
    chk("clean_pass", pass, 1);
    chk("clean_err", err, 0);
    chk("clean_fv", fv, 0);
    chk("clean_last_ops", {c0, a, b}, 9'h1FF);

    fault = 1;
    run(-1, -1, cnt);
    chk("s0_err", err, 256);
    chk("s0_fvec", fvec, 9'h001);
    chk("s0_fgot", fgot, 5'h00);
    chk("s0_pass", pass, 0);
    chk("sat_err", err2, 15);
    chk("sat_done", done2, 1);
    chk("sat_fvec", fvec2, 9'h001);

    fault = 2;
    run(-1, $urandom_range(10, 1500), cnt);
    chk("c4_err", err, 256);
    chk("c4_fvec", fvec, 9'h01F);
    chk("c4_fgot", fgot, 5'h00);
    chk("c4_latency", cnt, TOTAL);

    fault = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (99) @(negedge clk);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_state", {busy, done, c0, a, b}, 0);
    chk("abort_err_hold", err, 0);
    repeat (4) @(negedge clk);
    chk("abort_idle", {busy, done}, 0);
    run($urandom_range(5, 1500), -1, cnt);
    chk("restart_latency", cnt, TOTAL);
    chk("restart_pass", pass, 1);

    fault = 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat ($urandom_range(200, 1200)) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset", {busy, done, pass, c0, a, b, err, fv, fvec, fgot}, '0);
    chk("async_reset_sat", {busy2, done2, err2, fv2}, '0);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_reset_idle", {busy, done, c0, a, b}, 0);

    fault = int'($urandom_range(0, 2));
    run($urandom_range(5, 1500), $urandom_range(5, 1500), cnt);
    chk("random_latency", cnt, TOTAL);
    chk("random_err", err, (fault == 0) ? 0 : 256);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
